// File: rtl/rd_arbiter_if.sv
// Read-side bus between the FIFO read controller, the requesters and rd_arbiter.
// The arbiter connects through the slave modport; the environment drives the master side.
interface rd_arbiter_if #(
  parameter int P_DATA_MSB = 7
);
  logic [3:0]          i_req;
  logic                i_empty;
  logic [P_DATA_MSB:0] i_rd_data;
  logic                o_inc;
  logic [3:0]          o_gnt;
  logic [P_DATA_MSB:0] o_data;
  logic [3:0]          o_valid;

  modport master (
    output i_req, i_empty, i_rd_data,
    input  o_inc, o_gnt, o_data, o_valid
  );

  modport slave (
    input  i_req, i_empty, i_rd_data,
    output o_inc, o_gnt, o_data, o_valid
  );
endinterface

// File: rtl/rd_arbiter.sv
// Round-robin arbiter granting four requesters bursts of FIFO pops, with a
// two-stage return path delivering each popped word to its owner.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | no grant; picks next requester after last-served when FIFO non-empty
// S_GRANT | one requester owns the FIFO; pops up to P_BURST words, gap-spaced
module rd_arbiter #(
  parameter int P_DATA_MSB = 7,
  parameter int P_BURST    = 4,
  parameter int P_POP_GAP  = 2
) (
  input logic         i_clk,
  input logic         i_rst_n,
  rd_arbiter_if.slave bus
);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_GRANT = 1'b1;

  localparam logic [3:0] BURST_MAX = 4'(P_BURST);
  localparam logic [1:0] GAP_LOAD  = 2'(P_POP_GAP);

  logic [0:0]          state;
  logic [1:0]          last_idx;
  logic [1:0]          gnt_idx;
  logic [3:0]          gnt_q;
  logic [3:0]          burst_cnt;
  logic [1:0]          gap_cnt;

  logic                p1_vld;
  logic [1:0]          p1_idx;
  logic [3:0]          valid_q;
  logic [P_DATA_MSB:0] data_q;

  logic [1:0]          sel_idx;
  logic [1:0]          cand;
  logic                sel_found;
  logic                inc;
  logic                exit_now;

  // Upward search starting just past the last-served index, wrapping at 4.
  always_comb begin
    sel_idx   = last_idx + 2'd1;
    sel_found = 1'b0;
    cand      = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_idx + 2'(i);
      if (!sel_found && bus.i_req[cand]) begin
        sel_idx   = cand;
        sel_found = 1'b1;
      end
    end
  end

  assign inc = (state == S_GRANT) && bus.i_req[gnt_idx] && !bus.i_empty &&
               (burst_cnt < BURST_MAX) && (gap_cnt == 2'd0);

  // Empty is only trusted once the gap has let it reflect the previous pop.
  assign exit_now = (state == S_GRANT) && !inc &&
                    (!bus.i_req[gnt_idx] || (burst_cnt == BURST_MAX) ||
                     (bus.i_empty && (gap_cnt == 2'd0)));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      last_idx  <= 2'd3;
      gnt_idx   <= 2'd0;
      gnt_q     <= 4'd0;
      burst_cnt <= 4'd0;
      gap_cnt   <= 2'd0;
    end else begin
      if (inc) begin
        burst_cnt <= burst_cnt + 4'd1;
        gap_cnt   <= GAP_LOAD;
      end else if (gap_cnt != 2'd0) begin
        gap_cnt <= gap_cnt - 2'd1;
      end

      case (state)
        S_IDLE: begin
          if ((|bus.i_req) && !bus.i_empty) begin
            state     <= S_GRANT;
            gnt_idx   <= sel_idx;
            gnt_q     <= 4'b0001 << sel_idx;
            burst_cnt <= 4'd0;
          end
        end
        S_GRANT: begin
          if (exit_now) begin
            state    <= S_IDLE;
            gnt_q    <= 4'd0;
            last_idx <= gnt_idx;
          end
        end
        default: begin
          state <= S_IDLE;
          gnt_q <= 4'd0;
        end
      endcase
    end
  end

  // The owner tag travels with each pop, so words still in flight reach
  // the right requester after the grant has moved on.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      p1_vld  <= 1'b0;
      p1_idx  <= 2'd0;
      valid_q <= 4'd0;
      data_q  <= '0;
    end else begin
      p1_vld <= inc;
      if (inc) begin
        p1_idx <= gnt_idx;
      end
      valid_q <= p1_vld ? (4'b0001 << p1_idx) : 4'd0;
      if (p1_vld) begin
        data_q <= bus.i_rd_data;
      end
    end
  end

  assign bus.o_inc   = inc;
  assign bus.o_gnt   = gnt_q;
  assign bus.o_valid = valid_q;
  assign bus.o_data  = data_q;

endmodule

// File: tb/tb_rd_arbiter.sv
// Directed scenarios plus a random run on two arbiters (pop gap 0 and 2),
// compared each cycle against a behavioural model of grant ownership and delivery.
module tb_rd_arbiter;

  localparam int BURST = 4;

  logic i_clk   = 1'b0;
  logic i_rst_n = 1'b0;
  always #5 i_clk = ~i_clk;

  rd_arbiter_if #(.P_DATA_MSB(7)) a_if ();
  rd_arbiter_if #(.P_DATA_MSB(7)) b_if ();

  rd_arbiter #(.P_DATA_MSB(7), .P_BURST(BURST), .P_POP_GAP(0)) dut_a (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(a_if.slave));
  rd_arbiter #(.P_DATA_MSB(7), .P_BURST(BURST), .P_POP_GAP(2)) dut_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .bus(b_if.slave));

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] req = 4'd0;
  bit force_empty = 1'b0;
  bit topup = 1'b0;

  // FIFO contents per instance
  int fifo_mem [2][256];
  int rd_ptr [2];
  int wr_ptr [2];
  int rdv [2];

  // reference model per instance: owner = -1 means nobody holds the FIFO
  int owner [2];
  int last_srv [2];
  int pops [2];
  int cool [2];
  bit pend_v [2];
  int pend_idx [2];
  int pend_data [2];
  int exp_vidx [2];
  int exp_data [2];
  bit exp_inc [2];

  // observations of the DUTs for scenario-level checks
  int n_inc [2];
  int n_valb [2][4];
  int glog_a [$];
  logic [3:0] prev_gnt_a;

  function automatic int gap_of(int k);
    return (k == 0) ? 0 : 2;
  endfunction

  function automatic int fcount(int k);
    return wr_ptr[k] - rd_ptr[k];
  endfunction

  function automatic bit emp(int k);
    return force_empty || (fcount(k) == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int k, input int w);
    fifo_mem[k][wr_ptr[k] % 256] = w;
    wr_ptr[k]++;
  endtask

  task automatic fill(input int n);
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < n; i++) push(k, $urandom_range(0, 255));
  endtask

  task automatic flush();
    for (int k = 0; k < 2; k++) rd_ptr[k] = wr_ptr[k];
  endtask

  task automatic zero_counts();
    for (int k = 0; k < 2; k++) begin
      n_inc[k] = 0;
      for (int i = 0; i < 4; i++) n_valb[k][i] = 0;
    end
    glog_a.delete();
  endtask

  task automatic drive_env();
    a_if.i_req     = req;
    b_if.i_req     = req;
    a_if.i_empty   = emp(0);
    b_if.i_empty   = emp(1);
    a_if.i_rd_data = 8'(rdv[0]);
    b_if.i_rd_data = 8'(rdv[1]);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      owner[k] = -1; last_srv[k] = 3; pops[k] = 0; cool[k] = 0;
      pend_v[k] = 1'b0; pend_idx[k] = 0; pend_data[k] = 0;
      exp_vidx[k] = -1; exp_data[k] = 0; exp_inc[k] = 1'b0;
    end
    prev_gnt_a = 4'd0;
  endtask

  // One clock edge of the spec-level behaviour, using the inputs sampled before it.
  task automatic model_edge(input int k, input logic [3:0] rq, input bit em);
    bit cz;
    bit found;
    int c;
    cz = (cool[k] == 0);
    if (pend_v[k]) begin
      exp_vidx[k] = pend_idx[k];
      exp_data[k] = pend_data[k];
    end else begin
      exp_vidx[k] = -1;
    end
    pend_v[k] = exp_inc[k];
    if (exp_inc[k]) begin
      pend_idx[k]  = owner[k];
      pend_data[k] = fifo_mem[k][rd_ptr[k] % 256];
      rd_ptr[k]++;
      rdv[k] = pend_data[k];
    end else begin
      rdv[k] = $urandom_range(0, 255);
    end
    if (owner[k] < 0) begin
      if (cool[k] > 0) cool[k]--;
      if (rq != 4'd0 && !em) begin
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
          c = (last_srv[k] + i) % 4;
          if (!found && rq[c]) begin
            owner[k] = c;
            found = 1'b1;
          end
        end
        pops[k] = 0;
      end
    end else if (exp_inc[k]) begin
      pops[k]++;
      cool[k] = gap_of(k);
    end else begin
      if (cool[k] > 0) cool[k]--;
      if (!rq[owner[k]] || pops[k] == BURST || (em && cz)) begin
        last_srv[k] = owner[k];
        owner[k] = -1;
      end
    end
  endtask

  task automatic step();
    logic [3:0] req_s;
    bit emp_s [2];
    int gi;
    drive_env();
    #1;
    for (int k = 0; k < 2; k++) begin
      exp_inc[k] = (owner[k] >= 0) && req[owner[k]] && !emp(k) &&
                   (pops[k] < BURST) && (cool[k] == 0);
      emp_s[k] = emp(k);
    end
    chk("inc_a", 32'(a_if.o_inc), 32'(exp_inc[0]));
    chk("inc_b", 32'(b_if.o_inc), 32'(exp_inc[1]));
    if (a_if.o_inc) n_inc[0]++;
    if (b_if.o_inc) n_inc[1]++;
    req_s = req;
    @(posedge i_clk);
    for (int k = 0; k < 2; k++) model_edge(k, req_s, emp_s[k]);
    #1;
    if (topup)
      for (int k = 0; k < 2; k++)
        while (fcount(k) < 8) push(k, $urandom_range(0, 255));
    drive_env();
    chk("gnt_a", 32'(a_if.o_gnt), (owner[0] >= 0) ? (32'd1 << owner[0]) : 32'd0);
    chk("gnt_b", 32'(b_if.o_gnt), (owner[1] >= 0) ? (32'd1 << owner[1]) : 32'd0);
    chk("valid_a", 32'(a_if.o_valid), (exp_vidx[0] >= 0) ? (32'd1 << exp_vidx[0]) : 32'd0);
    chk("valid_b", 32'(b_if.o_valid), (exp_vidx[1] >= 0) ? (32'd1 << exp_vidx[1]) : 32'd0);
    chk("data_a", 32'(a_if.o_data), 32'(exp_data[0]));
    chk("data_b", 32'(b_if.o_data), 32'(exp_data[1]));
    for (int i = 0; i < 4; i++) begin
      if (a_if.o_valid == (4'b0001 << i)) n_valb[0][i]++;
      if (b_if.o_valid == (4'b0001 << i)) n_valb[1][i]++;
    end
    if (prev_gnt_a == 4'd0 && a_if.o_gnt != 4'd0) begin
      gi = -1;
      for (int i = 0; i < 4; i++) if (a_if.o_gnt[i]) gi = i;
      glog_a.push_back(gi);
    end
    prev_gnt_a = a_if.o_gnt;
  endtask

  // Asserts reset mid-cycle, checks the cleared outputs, releases after one edge.
  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    chk("rst_gnt_a", 32'(a_if.o_gnt), 32'd0);
    chk("rst_gnt_b", 32'(b_if.o_gnt), 32'd0);
    chk("rst_valid_a", 32'(a_if.o_valid), 32'd0);
    chk("rst_valid_b", 32'(b_if.o_valid), 32'd0);
    chk("rst_data_a", 32'(a_if.o_data), 32'd0);
    chk("rst_inc_a", 32'(a_if.o_inc), 32'd0);
    chk("rst_inc_b", 32'(b_if.o_inc), 32'd0);
    model_reset();
    @(posedge i_clk);
    #1;
    i_rst_n = 1'b1;
    drive_env();
  endtask

  initial begin
    int guard;
    bit dropped;
    for (int k = 0; k < 2; k++) begin
      rd_ptr[k] = 0; wr_ptr[k] = 0; rdv[k] = 0;
    end
    model_reset();
    zero_counts();
    drive_env();
    #1;

    // two requesters, 8 words, no pop gap on instance a
    req = 4'b0101;
    fill(8);
    do_reset();
    zero_counts();
    for (int i = 0; i < 6; i++) step();
    chk("burst_pops_a", 32'(n_inc[0]), 32'd4);
    chk("burst_valid0_a", 32'(n_valb[0][0]), 32'd4);
    for (int i = 0; i < 6; i++) step();
    chk("grant_cnt_a", 32'(glog_a.size() >= 2), 32'd1);
    if (glog_a.size() >= 2) begin
      chk("first_gnt_a", 32'(glog_a[0]), 32'd0);
      chk("second_gnt_a", 32'(glog_a[1]), 32'd2);
    end

    // single requester 1, three words, gap 2 on instance b
    req = 4'b0010;
    do_reset();
    flush();
    fill(3);
    zero_counts();
    for (int i = 0; i < 25; i++) step();
    chk("gap_pops_b", 32'(n_inc[1]), 32'd3);
    chk("gap_valid1_b", 32'(n_valb[1][1]), 32'd3);
    chk("gap_pops_a", 32'(n_inc[0]), 32'd3);

    // all four requesting, FIFO kept topped up
    req = 4'b1111;
    do_reset();
    flush();
    fill(8);
    topup = 1'b1;
    zero_counts();
    for (int i = 0; i < 50; i++) step();
    topup = 1'b0;
    chk("rotate_cnt_a", 32'(glog_a.size() >= 5), 32'd1);
    if (glog_a.size() >= 5)
      for (int i = 0; i < 5; i++) chk("rotate_a", 32'(glog_a[i]), 32'(i % 4));

    // requester 2 drops its request the cycle after its second pop
    req = 4'b0100;
    do_reset();
    flush();
    fill(12);
    zero_counts();
    dropped = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!dropped && pops[0] == 2) begin
        req = 4'b0000;
        dropped = 1'b1;
      end
    end
    chk("drop_valid2_a", 32'(n_valb[0][2]), 32'd2);

    // reset pulse one cycle after a pop discards the in-flight word
    req = 4'b0110;
    do_reset();
    flush();
    fill(10);
    guard = 0;
    while (!exp_inc[0] && guard < 10) begin
      step();
      guard++;
    end
    chk("rst_pop_seen_a", 32'(exp_inc[0]), 32'd1);
    do_reset();
    zero_counts();
    for (int i = 0; i < 2; i++) step();
    chk("rst_no_valid_a", 32'(n_valb[0][1] + n_valb[0][2]), 32'd0);
    chk("rst_first_gnt_n", 32'(glog_a.size()), 32'd1);
    if (glog_a.size() >= 1) chk("rst_first_gnt_a", 32'(glog_a[0]), 32'd1);
    for (int i = 0; i < 6; i++) step();

    // empty FIFO with everyone requesting: stays idle
    req = 4'b1111;
    force_empty = 1'b1;
    do_reset();
    zero_counts();
    for (int i = 0; i < 10; i++) step();
    chk("empty_inc_a", 32'(n_inc[0]), 32'd0);
    chk("empty_inc_b", 32'(n_inc[1]), 32'd0);
    chk("empty_gnt_a", 32'(glog_a.size()), 32'd0);
    force_empty = 1'b0;

    // random traffic
    flush();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1)
        for (int k = 0; k < 2; k++)
          if (fcount(k) < 200) push(k, $urandom_range(0, 255));
      if ($urandom_range(0, 15) == 0) force_empty = !force_empty;
      if ($urandom_range(0, 199) == 0) do_reset();
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rd_arbiter.md
RD_ARBITER -- requirements
Module: rd_arbiter

Interface
REQ-001 Parameter P_DATA_MSB, default 7: MSB index of the FIFO read data word.
REQ-002 Parameter P_BURST, default 4, range 1-15: maximum pops per grant before re-arbitration.
REQ-003 Parameter P_POP_GAP, default 2, range 0-3: idle cycles forced after each pop so i_empty reflects that pop.
REQ-004 i_clk  in  1  single clock; all state updates on its rising edge.
REQ-005 i_rst_n  in  1  asynchronous, active-low reset.
REQ-006 i_req  in  4  level request per requester; bit n = requester n wants words.
REQ-007 i_empty  in  1  FIFO empty flag from the read controller.
REQ-008 i_rd_data  in  P_DATA_MSB+1  FIFO read data, valid the cycle after an o_inc pulse.
REQ-009 o_inc  out  1  pop strobe to the read controller; one word per cycle high.
REQ-010 o_gnt  out  4  registered one-hot grant; all-zero when idle.
REQ-011 o_data  out  P_DATA_MSB+1  registered word delivered to the requester.
REQ-012 o_valid  out  4  registered one-hot; bit n = o_data belongs to requester n this cycle.

Function
REQ-013 FSM states are IDLE and GRANT; a 2-bit last-served pointer, a 4-bit burst counter and a 2-bit gap counter SHALL be kept.
REQ-014 IDLE: when any i_req bit is set and i_empty=0, select the first requesting index searching upward modulo 4 from last-served+1, load o_gnt one-hot, clear the burst counter and enter GRANT next cycle; otherwise remain in IDLE.
REQ-015 o_inc SHALL be combinational: high only in GRANT while i_req[granted]=1, i_empty=0, burst count < P_BURST and gap counter = 0.
REQ-016 Each o_inc cycle SHALL increment the burst counter and load the gap counter with P_POP_GAP; the gap counter decrements to 0 on cycles without o_inc.
REQ-017 GRANT exits to IDLE (o_gnt cleared, last-served := granted index) on the first cycle in which i_req[granted]=0, or burst count = P_BURST, or i_empty=1 while gap counter = 0.
REQ-018 An exit and a new IDLE selection SHALL NOT occur in the same cycle; at least one IDLE cycle separates consecutive grants.
REQ-019 Data path: o_inc in cycle N captures the granted index; i_rd_data sampled in N+1; o_data and o_valid[index] presented in N+2 for exactly one cycle; o_valid all-zero otherwise, o_data holds its last value.
REQ-020 The pipeline SHALL deliver in-flight words even if the grant ends or i_req drops after the pop; no pop is ever lost or duplicated.
REQ-021 A requester SHALL never receive o_valid without a prior matching o_inc; at most one o_valid bit is high at any time.
REQ-022 Requests not granted SHALL be held waiting with no side effects; round-robin guarantees each persistent requester a grant within 4 grants.

Reset
REQ-023 While i_rst_n=0: state=IDLE, o_gnt=0, o_valid=0, o_data=0, last-served=3 (requester 0 wins first), burst and gap counters=0, pipeline valids cleared; o_inc=0.
REQ-024 Reset assertion mid-burst SHALL discard in-flight words immediately; the first grant after release follows REQ-014 from last-served=3.

Verification
REQ-025 Reset release, i_req=4'b0101, FIFO holds 8 words, P_BURST=4, P_POP_GAP=0 -> o_gnt=0001, four consecutive o_inc, o_valid=0001 for 4 cycles starting 2 cycles after first pop, IDLE cycle, then o_gnt=0100.
REQ-026 P_POP_GAP=2, single requester 1, FIFO holds 3 words -> o_inc pulses spaced 3 cycles apart, exactly 3 o_valid=0010 pulses, exit on i_empty, no fourth pop.
REQ-027 All four requesting continuously, FIFO never empty -> grants rotate 0,1,2,3,0 with P_BURST pops each.
REQ-028 Requester 2 drops i_req the cycle after its second pop -> exactly 2 words delivered to requester 2, grant released next cycle.
REQ-029 i_rst_n pulsed low one cycle after an o_inc -> o_valid stays 0, o_gnt=0, next grant goes to lowest requesting index.
REQ-030 i_empty=1 with all i_req set -> remains IDLE, o_inc never asserted.
